// File: rtl/denise_sprite_shifter.sv
// One Denise sprite channel: POS/CTL/DATA/DATB registers, horizontal start
// comparator and the 64-bit A/B pattern shifters that emit one 2-bit pixel per shift.
module denise_sprite_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        clk7n_en,
  input  logic        aen,
  input  logic [1:0]  address,
  input  logic [8:0]  hpos,
  input  logic [15:0] fmode,
  input  logic        shift,
  input  logic [47:0] chip48,
  input  logic [15:0] data_in,
  output logic [1:0]  sprdata,
  output logic        attach
);

  typedef enum logic [1:0] {
    REG_POS  = 2'd0,
    REG_CTL  = 2'd1,
    REG_DATA = 2'd2,
    REG_DATB = 2'd3
  } reg_sel_e;

  logic [8:0]  hstart;
  logic        armed;
  logic        load;
  logic        load_del;
  logic [63:0] datla;
  logic [63:0] datlb;
  logic [63:0] shifta;
  logic [63:0] shiftb;
  logic [63:0] fetch_data;
  logic        hmatch;
  logic        reg_wr;

  // Only the fetch-width and SSCAN2 fields of FMODE matter to a sprite channel.
  logic unused_fmode;
  assign unused_fmode = ^{fmode[14:4], fmode[1:0]};

  assign reg_wr = clk7_en & aen;

  // Wider fetches place the extra bus words below the CPU-visible data word.
  always_comb begin
    fetch_data = '0;
    unique case (fmode[3:2])
      2'b00:   fetch_data = {data_in, 48'h0};
      2'b11:   fetch_data = {data_in, chip48};
      default: fetch_data = {data_in, chip48[47:32], 32'h0};
    endcase
  end

  // SSCAN2 ignores hstart bit 8 so the sprite repeats in both halves of the line.
  assign hmatch = (hpos[7:0] == hstart[7:0]) & (fmode[15] | (hpos[8] == hstart[8]));

  always_ff @(posedge clk) begin
    if (reset) begin
      hstart   <= '0;
      attach   <= 1'b0;
      armed    <= 1'b0;
      load     <= 1'b0;
      load_del <= 1'b0;
      datla    <= '0;
      datlb    <= '0;
    end else begin
      if (reg_wr) begin
        unique case (reg_sel_e'(address))
          REG_POS:  hstart[8:1] <= data_in[7:0];
          REG_CTL: begin
            hstart[0] <= data_in[0];
            attach    <= data_in[7];
            armed     <= 1'b0;
          end
          REG_DATA: begin
            datla <= fetch_data;
            armed <= 1'b1;
          end
          REG_DATB: datlb <= fetch_data;
        endcase
      end
      if (clk7_en) begin
        load <= armed & hmatch;
      end
      if (clk7n_en) begin
        load_del <= load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shifta <= '0;
      shiftb <= '0;
    end else if (load_del && clk7n_en) begin
      shifta <= datla;
      shiftb <= datlb;
    end else if (shift) begin
      shifta <= {shifta[62:0], 1'b0};
      shiftb <= {shiftb[62:0], 1'b0};
    end
  end

  assign sprdata = {shiftb[63], shifta[63]};

endmodule

// File: tb/tb_denise_sprite_shifter.sv
// Scoreboard bench for denise_sprite_shifter: a pixel-queue reference model
// predicts {sprdata, attach} after every clock; a monitor compares independently.
module tb_denise_sprite_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk7_en = 1'b0;
  logic        clk7n_en = 1'b0;
  logic        aen = 1'b0;
  logic [1:0]  address = '0;
  logic [8:0]  hpos = '0;
  logic [15:0] fmode = '0;
  logic        shift = 1'b0;
  logic [47:0] chip48 = '0;
  logic [15:0] data_in = '0;
  logic [1:0]  sprdata;
  logic        attach;

  int checks = 0;
  int errors = 0;
  int cnum = 0;

  typedef struct {
    int       cyc;
    logic [2:0] v;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  int          m_hstart;
  bit          m_attach, m_armed, m_load, m_load_del;
  logic [63:0] m_lata, m_latb;
  logic [1:0]  pix_q[$];

  denise_sprite_shifter dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .clk7n_en(clk7n_en),
    .aen(aen), .address(address), .hpos(hpos), .fmode(fmode), .shift(shift),
    .chip48(chip48), .data_in(data_in), .sprdata(sprdata), .attach(attach)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fmt(input logic [1:0] w, input logic [15:0] d,
                                      input logic [47:0] c);
    if (w == 2'b00)      return {d, 48'h0};
    else if (w == 2'b11) return {d, c};
    else                 return {d, c[47:32], 32'h0};
  endfunction

  // Advance the model across the coming rising edge using the inputs now driven.
  task automatic model_step();
    int          old_hs;
    bit          old_armed, old_load, old_ld;
    logic [63:0] old_a, old_b;
    logic [1:0]  front;
    exp_t        e;
    if (reset) begin
      m_hstart = 0; m_attach = 0; m_armed = 0; m_load = 0; m_load_del = 0;
      m_lata = '0; m_latb = '0;
      pix_q.delete();
    end else begin
      old_hs = m_hstart; old_armed = m_armed; old_load = m_load; old_ld = m_load_del;
      old_a = m_lata; old_b = m_latb;
      if (clk7_en && aen) begin
        case (address)
          2'd0: m_hstart = (m_hstart % 2) + 2 * int'(data_in[7:0]);
          2'd1: begin
            m_hstart = (m_hstart / 2) * 2 + int'(data_in[0]);
            m_attach = data_in[7];
            m_armed = 0;
          end
          2'd2: begin m_lata = fmt(fmode[3:2], data_in, chip48); m_armed = 1; end
          default: m_latb = fmt(fmode[3:2], data_in, chip48);
        endcase
      end
      if (clk7_en)
        m_load = old_armed && ((int'(hpos) % 256) == (old_hs % 256)) &&
                 (fmode[15] || ((int'(hpos) / 256) == (old_hs / 256)));
      if (clk7n_en) m_load_del = old_load;
      if (old_ld && clk7n_en) begin
        pix_q.delete();
        for (int unsigned i = 0; i < 64; i++) pix_q.push_back({old_b[63-i], old_a[63-i]});
      end else if (shift && pix_q.size() > 0) begin
        void'(pix_q.pop_front());
      end
    end
    front = (pix_q.size() > 0) ? pix_q[0] : 2'b00;
    e.cyc = cnum;
    e.v = {front, m_attach};
    sb.push_back(e);
  endtask

  task automatic cyc();
    clk7_en  = (cnum % 4 == 0);
    clk7n_en = (cnum % 4 == 2);
    model_step();
    cnum++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit inc);
    repeat (n) begin
      cyc();
      if (inc && (cnum % 4 == 1)) hpos = hpos + 9'd1;
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
    while (cnum % 4 != 0) cyc();
    aen = 1'b1; address = a; data_in = d;
    cyc();
    aen = 1'b0; data_in = '0;
  endtask

  // Monitor: every edge the DUT presents a pixel; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({sprdata, attach} !== e.v) begin
          errors++;
          $display("FAIL pixel cyc=%0d got sprdata=%b attach=%b want sprdata=%b attach=%b",
                   e.cyc, sprdata, attach, e.v[2:1], e.v[0]);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    // Reset, then idle with a sweeping beam
    reset = 1'b1; shift = 1'b1;
    run(4, 0);
    reset = 1'b0;
    hpos = 9'h000;
    run(1200, 1);

    // 16-bit fetch, attach set, pattern 0x8001 at hstart 0x080
    fmode = 16'h0000;
    write_reg(2'd0, 16'h0040);
    write_reg(2'd1, 16'h0080);
    write_reg(2'd3, 16'h0000);
    write_reg(2'd2, 16'h8001);
    hpos = 9'h07C;
    run(120, 1);

    // Disarmed: sweep through the start position again
    write_reg(2'd1, 16'h0080);
    hpos = 9'h070;
    run(160, 1);

    // 64-bit fetch with chip-bus data
    fmode = 16'h000C; chip48 = 48'hFFFF_0000_0001;
    write_reg(2'd2, 16'h0000);
    fmode = 16'h0000; chip48 = '0;
    hpos = 9'h07C;
    run(120, 1);

    // SSCAN2 ignores hstart bit 8
    write_reg(2'd1, 16'h0000);
    write_reg(2'd0, 16'h0020);
    write_reg(2'd3, 16'hF0F0);
    write_reg(2'd2, 16'hAAAA);
    fmode = 16'h8000; hpos = 9'h13E;
    run(80, 1);
    fmode = 16'h0000;
    write_reg(2'd1, 16'h0000);
    write_reg(2'd2, 16'hAAAA);
    hpos = 9'h13E;
    run(80, 1);

    // Frozen output with shift held low, then reset mid-stream
    write_reg(2'd1, 16'h0000);
    write_reg(2'd0, 16'h0040);
    write_reg(2'd3, 16'hFFFF);
    write_reg(2'd2, 16'h8001);
    shift = 1'b0; hpos = 9'h07E;
    run(40, 1);
    reset = 1'b1;
    run(1, 0);
    reset = 1'b0;
    shift = 1'b1;
    run(8, 1);

    // Randomised traffic around a small hstart window
    for (int i = 0; i < 4000; i++) begin
      aen     = ($urandom_range(0, 3) == 0);
      address = 2'($urandom_range(0, 3));
      data_in = 16'($urandom);
      if (address == 2'd0) data_in[7:0] = 8'($urandom_range(0, 3));
      hpos    = {1'($urandom), 5'b0, 3'($urandom_range(0, 7))};
      fmode   = 16'($urandom) & 16'h800C;
      chip48  = {16'($urandom), 16'($urandom), 16'($urandom)};
      shift   = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 499) == 0);
      cyc();
    end
    aen = 1'b0; reset = 1'b0;
    run(4, 0);

    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
